top_uart_logger: RTL and testbench

TOP_UART_LOGGER -- requirements
Module: top_uart_logger

---
 rtl/top_uart_logger.sv | 159 +++++++++++++++
 tb/tb_top_uart_logger.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/top_uart_logger.sv
// Event logger: buffers {id,start,end,delta} tuples in a FIFO and prints each
// one as a 56-character uppercase-hex CSV line over an 8N1 UART transmitter.
module top_uart_logger #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        out_valid,
  output logic        out_ready,
  input  logic [15:0] out_id,
  input  logic [63:0] out_start_ts,
  input  logic [63:0] out_end_ts,
  input  logic [63:0] out_delta,
  output logic        tx
);
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int EW         = 208;
  localparam int LAST_CHAR  = 55;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, NEXT} fmt_state_e;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_ni = rst_sync_q[1];

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          full, empty, wr_en, rd_en;

  fmt_state_e    state_q;
  logic [5:0]    idx_q;
  logic [EW-1:0] entry_q;
  logic          uart_busy_q;
  logic          tx_accept;
  logic [CW-1:0] cyc_q;
  logic [3:0]    bit_q;
  logic [9:0]    frame_q;
  logic          tx_q;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign out_ready = rst_ni && !full;
  assign wr_en     = out_valid && out_ready;
  assign rd_en     = (state_q == LOAD);
  assign tx_accept = (state_q == SEND) && !uart_busy_q;
  assign tx        = tx_q;

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= {out_id, out_start_ts, out_end_ts, out_delta};
  end

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character positions map onto the 52 nibbles of the entry, MSB first,
  // with separators at 4, 21, 38 and the newline at 55.
  function automatic logic [7:0] line_char(input logic [EW-1:0] e, input logic [5:0] idx);
    logic [5:0] digit;
    logic [7:0] shamt;
    logic [7:0] ch;
    digit = idx;
    if (idx >= 6'd39)      digit = idx - 6'd3;
    else if (idx >= 6'd22) digit = idx - 6'd2;
    else if (idx >= 6'd5)  digit = idx - 6'd1;
    shamt = 8'd204 - {digit, 2'b00};
    if (idx == 6'd4 || idx == 6'd21 || idx == 6'd38) ch = 8'h2C;
    else if (idx == 6'(LAST_CHAR))                    ch = 8'h0A;
    else                                              ch = hex_ascii(e[shamt +: 4]);
    return ch;
  endfunction

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (!empty) state_q <= LOAD;
        LOAD: begin
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: if (tx_accept) state_q <= NEXT;
        NEXT: begin
          if (idx_q == 6'(LAST_CHAR)) begin
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 6'd1;
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The latched entry only changes on a pop, so new accepts never disturb a line in flight.
  always_ff @(posedge clk) begin
    if (rd_en) entry_q <= mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (tx_accept) frame_q <= {1'b1, line_char(entry_q, idx_q), 1'b0};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      uart_busy_q <= 1'b0;
      cyc_q       <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
    end else if (!uart_busy_q) begin
      if (tx_accept) begin
        uart_busy_q <= 1'b1;
        cyc_q       <= '0;
        bit_q       <= '0;
        tx_q        <= 1'b0;
      end
    end else if (cyc_q == CW'(BIT_CYCLES - 1)) begin
      cyc_q <= '0;
      if (bit_q == 4'd9) begin
        uart_busy_q <= 1'b0;
        tx_q        <= 1'b1;
      end else begin
        bit_q <= bit_q + 4'd1;
        tx_q  <= frame_q[bit_q + 4'd1];
      end
    end else begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_top_uart_logger.sv
// Bench for top_uart_logger: a UART receiver monitor checks every byte against
// a queue of expected characters filled by the stimulus from a string-level model.
module tb_top_uart_logger;
  localparam int CLK_HZ = 4_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int FD     = 4;
  localparam int B      = CLK_HZ / BAUD;
  localparam int DRAIN  = 56 * (10 * B + 4) * (FD + 3);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_valid = 1'b0;
  logic        out_ready;
  logic [15:0] out_id = '0;
  logic [63:0] out_start_ts = '0;
  logic [63:0] out_end_ts = '0;
  logic [63:0] out_delta = '0;
  logic        tx;

  top_uart_logger #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_start_ts(out_start_ts), .out_end_ts(out_end_ts),
    .out_delta(out_delta), .tx(tx)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  string      HX = "0123456789ABCDEF";

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_hex(input logic [63:0] v, input int nd);
    for (int i = nd - 1; i >= 0; i--) exp_q.push_back(HX[v[4*i +: 4]]);
  endtask

  task automatic push_model(input logic [15:0] id, input logic [63:0] s, e, d);
    push_hex(64'(id), 4); exp_q.push_back(8'h2C);
    push_hex(s, 16);      exp_q.push_back(8'h2C);
    push_hex(e, 16);      exp_q.push_back(8'h2C);
    push_hex(d, 16);      exp_q.push_back(8'h0A);
  endtask

  task automatic send_event(input logic [15:0] id, input logic [63:0] s, e, d, input string lit);
    int t;
    t = 0;
    @(negedge clk);
    out_id = id; out_start_ts = s; out_end_ts = e; out_delta = d; out_valid = 1'b1;
    while (!out_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!out_ready) begin
      check(1'b0, "accept_timeout", 64'(t), 64'd20000);
      out_valid = 1'b0;
      return;
    end
    if (lit.len() > 0) push_str(lit);
    else               push_model(id, s, e, d);
    @(posedge clk);
    #1 out_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < DRAIN) begin
      @(negedge clk);
      t++;
    end
    check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge clk);
  endtask

  initial begin : monitor
    bit         samp [10*B];
    logic [7:0] got, eb;
    int         gap, line_pos;
    bit         aborted, stable, chk_bnd;
    gap = 0; line_pos = 0; chk_bnd = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        line_pos = 0; gap = 0; chk_bnd = 1'b0;
      end else if (tx === 1'b1) begin
        gap++;
      end else begin
        aborted = 1'b0;
        samp[0] = tx;
        for (int m = 1; m < 10*B; m++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          samp[m] = tx;
        end
        if (aborted) begin
          line_pos = 0; chk_bnd = 1'b0;
        end else begin
          if (line_pos != 0) check(gap <= 2, "byte_gap", 64'(gap), 64'd2);
          else if (chk_bnd)  check(gap <= 4, "line_gap", 64'(gap), 64'd4);
          stable = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < B; j++)
              if (samp[k*B + j] != samp[k*B + B/2]) stable = 1'b0;
          got = '0;
          for (int k = 0; k < 8; k++) got[k] = samp[(k+1)*B + B/2];
          check(stable, "bit_width", 64'(stable), 64'd1);
          check(samp[B/2] == 1'b0 && samp[9*B + B/2] == 1'b1, "framing",
                64'({samp[9*B + B/2], samp[B/2]}), 64'd2);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", 64'(got), 64'd0);
          end else begin
            eb = exp_q.pop_front();
            check(got == eb, "byte", 64'(got), 64'(eb));
          end
          line_pos = (line_pos + 1) % 56;
          chk_bnd  = (line_pos == 0) && (exp_q.size() > 0);
        end
        gap = 0;
      end
    end
  end

  initial begin : stim
    int          t, acc, first_drop;
    bit          ok_tx, ok_rdy;
    logic [15:0] rid;
    logic [63:0] rs, re, rd;

    repeat (3) @(negedge clk);
    check(tx == 1'b1, "reset_tx", 64'(tx), 64'd1);
    check(out_ready == 1'b0, "reset_ready", 64'(out_ready), 64'd0);
    rst_n = 1'b1;
    t = 0;
    while (!out_ready && t < 4) begin
      @(negedge clk);
      t++;
    end
    check(out_ready == 1'b1, "ready_after_reset", 64'(t), 64'd4);

    ok_tx = 1'b1; ok_rdy = 1'b1;
    for (int i = 0; i < 10*56*B; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_tx = 1'b0;
      if (out_ready !== 1'b1) ok_rdy = 1'b0;
    end
    check(ok_tx, "idle_tx", 64'(ok_tx), 64'd1);
    check(ok_rdy, "idle_ready", 64'(ok_rdy), 64'd1);

    send_event(16'h0012, 64'h0123456789ABCDEF, 64'h00000000000000A5, 64'h00000000FEDCBA98,
               "0012,0123456789ABCDEF,00000000000000A5,00000000FEDCBA98\n");
    t = 0;
    while (tx === 1'b1 && t < 8) begin
      @(posedge clk);
      #1 t++;
    end
    check(tx == 1'b0, "first_start_latency", 64'(t), 64'd8);
    send_event(16'hABCD, 64'hDEADBEEFCAFEBABE, 64'h0000000000000001, 64'h1122334455667788,
               "ABCD,DEADBEEFCAFEBABE,0000000000000001,1122334455667788\n");
    send_event(16'hFFFF, '1, '1, '1,
               "FFFF,FFFFFFFFFFFFFFFF,FFFFFFFFFFFFFFFF,FFFFFFFFFFFFFFFF\n");
    send_event(16'h0000, '0, '0, '0,
               "0000,0000000000000000,0000000000000000,0000000000000000\n");
    wait_drain();

    acc = 0; first_drop = -1; t = 0;
    rid = 16'h1000; rs = {$urandom, $urandom}; re = {$urandom, $urandom}; rd = {$urandom, $urandom};
    while (acc < FD + 2 && t < 40000) begin
      @(negedge clk);
      t++;
      out_valid = 1'b1;
      out_id = rid; out_start_ts = rs; out_end_ts = re; out_delta = rd;
      if (out_ready) begin
        push_model(rid, rs, re, rd);
        acc++;
        rid = 16'h1000 + 16'(acc);
        rs = {$urandom, $urandom}; re = {$urandom, $urandom}; rd = {$urandom, $urandom};
      end else if (first_drop < 0) begin
        first_drop = acc;
      end
    end
    @(negedge clk);
    out_valid = 1'b0;
    check(acc == FD + 2, "burst_accepts", 64'(acc), 64'(FD + 2));
    check(first_drop == FD + 1, "burst_ready_drop", 64'(first_drop), 64'(FD + 1));
    wait_drain();

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      send_event(16'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "");
    end
    wait_drain();

    send_event(16'h5A5A, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "");
    send_event(16'hA5A5, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "");
    repeat (300) @(negedge clk);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check(tx == 1'b1, "abort_tx", 64'(tx), 64'd1);
    check(out_ready == 1'b0, "abort_ready", 64'(out_ready), 64'd0);
    exp_q.delete();
    ok_tx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_tx = 1'b0;
    end
    check(ok_tx, "reset_hold_tx", 64'(ok_tx), 64'd1);
    rst_n = 1'b1;
    t = 0;
    while (!out_ready && t < 4) begin
      @(negedge clk);
      t++;
    end
    check(out_ready == 1'b1, "ready_after_abort", 64'(t), 64'd4);
    ok_tx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) ok_tx = 1'b0;
    end
    check(ok_tx, "no_residue_tx", 64'(ok_tx), 64'd1);
    send_event(16'h0BEE, 64'h0F1E2D3C4B5A6978, 64'h8000000000000000, 64'h0000000000000010, "");
    wait_drain();

    check(exp_q.size() == 0, "leftover", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #(90000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
